rr_encoder_arbiter: RTL and testbench
=====================================

# rr_encoder_arbiter

Four-input round-robin arbiter that shares one downstream resource among four requesters. It produces a registered one-hot grant and the matching 2-bit encoded grant index, which is the same 4-to-2 mapping the team's `encoder` block produces. A programmable hold limit forces rotation, so one requester cannot monopolise the resource while others wait. It sits between the requester bank and the shared datapath and drives that datapath's select lines.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while other requests are pending. Legal range 1..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req`  input  4  request vector; bit n = requester n. Level-sensitive; held high for as long as ownership is wanted.
- `gnt`  output  4  one-hot grant, registered. 0000 when no owner.
- `gnt_id`  output  2  encoded index of the `gnt` bit (0001→00, 0010→01, 0100→10, 1000→11). 00 when idle.
- `gnt_valid`  output  1  high while any `gnt` bit is high.

## Operation
- Internal state:
  - FSM state IDLE/GRANT.
  - `ptr[1:0]`: first requester searched next.
  - `owner[1:0]`.
  - `cnt[3:0]`: cycles owned.
- Round-robin search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, wrapping mod 4. The first set bit wins.
- **IDLE**
  - `req`=0000: stay in IDLE, outputs zero.
  - Any request: grant the search winner, set `owner` to the winner, clear `cnt`, go to GRANT.
- **GRANT**, evaluated every edge:
  - **Release.** `req[owner]`=0:
    - Set `ptr` to `owner+1`.
    - If any other request is pending, grant the search winner (starting at the new `ptr`) on this same edge, clear `cnt`, stay in GRANT.
    - Otherwise clear `gnt`, go to IDLE.
  - **Expiry.** `req[owner]`=1, `cnt` = `MAX_HOLD-1`, and at least one other request pending:
    - Set `ptr` to `owner+1`.
    - Hand off to the search winner, which is never the current owner.
    - Clear `cnt`.
  - **Hold.** Any other case: keep the grant and increment `cnt`, saturating at `MAX_HOLD-1`. A sole requester keeps the grant indefinitely.
- Invariants:
  - `gnt` is always 0000 or one-hot.
  - `gnt_id` always equals the encoding of `gnt`.
  - `gnt_valid` = |`gnt`.
- Reset:
  - `gnt`=0000, `gnt_id`=00, `gnt_valid`=0.
  - `ptr`=0, `owner`=0, `cnt`=0, state IDLE.
  - Reset has priority over every other event, including mid-grant: the grant drops at the reset edge.

## Timing
- Request to grant: request sampled at edge k, grant visible from edge k (registered output, stable for cycle k+1). One-cycle latency.
- Release to drop: `req[owner]` low at edge k clears or moves `gnt` at that same edge. The requester must treat `gnt` as advisory until `req` falls.
- Handoff has zero bubble: the new `gnt` replaces the old one at a single edge, with no 0000 cycle, whenever another request is pending.
- With all four requesting continuously, each requester holds for exactly `MAX_HOLD` cycles. The rotation period is 4×`MAX_HOLD` cycles.
- A request that rises on the same edge as a release or expiry takes part in that edge's search.
- A request dropped by a waiting (non-owner) requester before it is granted is simply forgotten; nothing is queued.
- `MAX_HOLD`=1: ownership rotates every cycle under contention.

## Test plan
- **Reset.** `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `gnt_id`=00, `gnt_valid`=0 throughout. After `rst` falls → `gnt`=0001 at the next edge.
- **Single request.** After reset, `req`=0100 → next edge `gnt`=0100, `gnt_id`=10, `gnt_valid`=1. Drop `req` → next edge all zero, and `ptr` is 3.
- **Full contention** (`MAX_HOLD`=8). `req`=1111 held for 40 cycles → grants in order 0001, 0010, 0100, 1000, 0001, each exactly 8 cycles, with no 0000 cycle between them.
- **Pointer fairness.** Requester 2 releases (`ptr`=3), then `req`=1001 → `gnt`=1000 (id 11). On requester 3 release → `gnt`=0001 (id 00) at the same edge.
- **Sole holder.** `req`=0010 for 20 cycles → `gnt`=0010 for all 20 cycles with no forced release. Raise `req[0]` at cycle 20 → handoff to 0001 no later than `MAX_HOLD` cycles after `req[0]` rises.
- **Reset mid-operation.** `rst` pulsed while `gnt`=0100 under `req`=1111 → outputs zero at the reset edge. After release → `gnt`=0001 at the next edge (`ptr` reset to 0).

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// Four-input round-robin arbiter with a registered one-hot grant, its encoded
// index, and a hold limit that forces rotation while other requests wait.
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] next_ptr;
  logic       others_pending;

  // First set bit of r in the order start, start+1, ... (mod 4). The loop
  // walks backwards so the earliest position in that order wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign next_ptr       = owner_q + 2'd1;
  assign others_pending = |(req & ~(4'b0001 << owner_q));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of latches.
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req, ptr_q);
          cnt_d   = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          ptr_d = next_ptr;
          if (others_pending) begin
            owner_d = rr_pick(req, next_ptr);
            cnt_d   = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == HOLD_LAST && others_pending) begin
          // Owner is last in the search order, so the winner is someone else.
          ptr_d   = next_ptr;
          owner_d = rr_pick(req, next_ptr);
          cnt_d   = 4'd0;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d    = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
    gnt_id_d = (state_d == GRANT) ? owner_d : 2'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational block.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      cnt_q    <= 4'd0;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench: two arbiters (hold limits 8 and 1) driven in lockstep and
// compared every cycle against a cycle-count reference model, plus directed cases.
module tb_rr_encoder_arbiter;

  localparam int N = 2;
  localparam int MH [N] = '{8, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_w   [N];
  logic [1:0] gnt_id_w[N];
  logic       valid_w [N];

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 = none), search start, cycles owned.
  int m_owner[N];
  int m_ptr  [N];
  int m_held [N];

  always #5 clk = ~clk;

  rr_encoder_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[0]), .gnt_id(gnt_id_w[0]), .gnt_valid(valid_w[0])
  );

  rr_encoder_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[1]), .gnt_id(gnt_id_w[1]), .gnt_valid(valid_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [3:0] r, input logic rs);
    logic [3:0] others;
    if (rs) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_held[k]  = 0;
    end else if (m_owner[k] < 0) begin
      if (r != 4'b0000) begin
        m_owner[k] = search(r, m_ptr[k]);
        m_held[k]  = 1;
      end
    end else begin
      others = r & ~(4'b0001 << m_owner[k]);
      if (!r[m_owner[k]]) begin
        m_ptr[k] = (m_owner[k] + 1) % 4;
        if (others != 4'b0000) begin
          m_owner[k] = search(r, m_ptr[k]);
          m_held[k]  = 1;
        end else begin
          m_owner[k] = -1;
        end
      end else if (m_held[k] >= MH[k] && others != 4'b0000) begin
        m_ptr[k]   = (m_owner[k] + 1) % 4;
        m_owner[k] = search(r, m_ptr[k]);
        m_held[k]  = 1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  // Apply inputs, advance one edge, update the model, then compare 1 ns later.
  task automatic step(input logic [3:0] r, input logic rs);
    logic [3:0] eg;
    logic [1:0] eid;
    req = r;
    rst = rs;
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k, r, rs);
    #1;
    for (int k = 0; k < N; k++) begin
      eg  = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
      eid = (m_owner[k] < 0) ? 2'd0 : 2'(m_owner[k]);
      check($sformatf("gnt[mh%0d]", MH[k]), 32'(gnt_w[k]), 32'(eg));
      check($sformatf("gnt_id[mh%0d]", MH[k]), 32'(gnt_id_w[k]), 32'(eid));
      check($sformatf("valid[mh%0d]", MH[k]), 32'(valid_w[k]), 32'(eg != 4'b0000));
    end
  endtask

  initial begin
    logic [3:0] r;
    int c;

    for (int k = 0; k < N; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_held[k]  = 0;
    end
    req = 4'b0000;
    rst = 1'b1;
    #2;

    // Reset with all requesting: outputs stay zero, then requester 0 wins.
    step(4'b1111, 1'b1);
    check("reset_gnt", 32'(gnt_w[0]), 32'h0);
    step(4'b1111, 1'b1);
    check("reset_valid", 32'(valid_w[0]), 32'h0);
    step(4'b1111, 1'b0);
    check("post_reset_gnt", 32'(gnt_w[0]), 32'h1);

    // Single request, release, then pointer fairness from ptr=3.
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    check("single_gnt", 32'(gnt_w[0]), 32'h4);
    check("single_id", 32'(gnt_id_w[0]), 32'h2);
    step(4'b0000, 1'b0);
    check("single_drop", 32'(gnt_w[0]), 32'h0);
    step(4'b1001, 1'b0);
    check("fair_gnt", 32'(gnt_w[0]), 32'h8);
    check("fair_id", 32'(gnt_id_w[0]), 32'h3);
    step(4'b0001, 1'b0);
    check("fair_handoff", 32'(gnt_w[0]), 32'h1);
    check("fair_handoff_id", 32'(gnt_id_w[0]), 32'h0);

    // Full contention: fixed rotation, no empty cycle.
    step(4'b0000, 1'b1);
    for (c = 0; c < 40; c++) begin
      step(4'b1111, 1'b0);
      check("rot8", 32'(gnt_w[0]), 32'(4'b0001 << ((c / 8) % 4)));
      check("rot1", 32'(gnt_w[1]), 32'(4'b0001 << (c % 4)));
    end

    // Sole holder keeps the grant, then yields once requester 0 appears.
    step(4'b0000, 1'b1);
    for (c = 0; c < 20; c++) begin
      step(4'b0010, 1'b0);
      check("sole_hold", 32'(gnt_w[0]), 32'h2);
    end
    c = 0;
    do begin
      step(4'b0011, 1'b0);
      c++;
    end while (gnt_w[0] != 4'b0001 && c < 8);
    check("sole_yield", 32'(gnt_w[0]), 32'h1);

    // Reset in the middle of a grant to requester 2.
    step(4'b0000, 1'b1);
    c = 0;
    do begin
      step(4'b1111, 1'b0);
      c++;
    end while (gnt_w[0] != 4'b0100 && c < 30);
    check("mid_reach", 32'(gnt_w[0]), 32'h4);
    step(4'b1111, 1'b1);
    check("mid_reset_gnt", 32'(gnt_w[0]), 32'h0);
    check("mid_reset_id", 32'(gnt_id_w[0]), 32'h0);
    step(4'b1111, 1'b0);
    check("mid_restart", 32'(gnt_w[0]), 32'h1);

    // Random traffic: each bit toggles occasionally so grants persist.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
